byte_stream_packer: RTL and testbench
=====================================

// Module: byte_stream_packer
// PURPOSE
//  Downstream consumer of the 8-bit per-cycle output of the counter/incrementer stage.
//  Packs successive bytes into LANES-byte words and buffers them in a small FIFO.
//  Presents the words on a ready/valid interface to the bus/DMA side.
//  The upstream cannot be back-pressured, so a full FIFO drops the word and raises a sticky flag.
// PARAMETERS
//  LANES  4  bytes per output word; 2..8
//  DEPTH  2  output FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          in_data is a valid byte this cycle
//  in_data    in   8          byte from the upstream stage
//  flush      in   1          emit the pending partial word
//  out_valid  out  1          FIFO head valid
//  out_ready  in   1          consumer accepts the head when out_valid & out_ready
//  out_data   out  8*LANES    packed word; byte k at [8k+7:8k], first byte at LSB
//  out_keep   out  LANES      bit k = byte k meaningful
//  overflow   out  1          sticky: a word was dropped
//  clr_ovf    in   1          clears overflow
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO empty; byte index cnt=0; accumulator=0.
//   - out_valid=0, out_data=0, out_keep=0, overflow=0.
//   - Reset mid-word discards the partial word. Reset with a full FIFO discards all entries.
//  Packing:
//   - in_valid: in_data is written to lane cnt, then cnt increments.
//   - At cnt==LANES-1 with in_valid, the word completes: it is pushed with keep=all ones, and cnt wraps to 0.
//  Flush (cnt>0, or in_valid this cycle):
//   - Pushes the partial word; includes the current byte if in_valid.
//   - keep = ones in the lanes written; unwritten lanes hold 0.
//   - cnt -> 0.
//   - Flush with cnt==0 and in_valid=0 is a no-op; no empty word is emitted.
//   - Flush on the cycle a word completes pushes that single full word only.
//  Latency: the push occurs at the edge that accepts the last byte. out_valid is high from the next cycle.
//  FIFO:
//   - Pop when out_valid & out_ready.
//   - out_data, out_keep and out_valid are registered from the head entry. They are stable while out_valid & !out_ready.
//   - Push and pop in the same cycle are both honoured, including when the FIFO is full.
//   - out_data and out_keep read 0 when the FIFO is empty.
//  Overflow:
//   - A push while full without a simultaneous pop drops the word, sets overflow and still resets cnt.
//   - clr_ovf clears overflow. A drop on the same cycle wins, so overflow stays 1.
//   - in_valid=0 cycles are ignored and gaps are allowed mid-word.
// CONFIGURATION
//  BYTE_PACKER_PARITY_EN defined:
//   - Adds port out_par (out, LANES): bit k = ^byte k (even parity).
//   - Parity is stored in the FIFO alongside the data.
//   - Unwritten lanes have parity 0. Reset value is 0.
//  BYTE_PACKER_PARITY_EN undefined: out_par port and parity storage are absent. All other behaviour is identical.
// TESTING (LANES=4, DEPTH=2)
//  1. in_valid=1 with bytes 01,02,03,04; out_ready=1 -> the cycle after byte 04: out_valid=1, out_data=32'h04030201, out_keep=4'hF.
//  2. Bytes AA,BB then flush with in_valid=0 -> out_data=32'h0000BBAA, out_keep=4'h3. A second flush gives no output.
//  3. out_ready=0 while streaming 12 bytes 00..0B -> FIFO holds 32'h03020100 and 32'h07060504. The third word is dropped and overflow=1. Raise out_ready: exactly 2 words drain.
//  4. FIFO full with out_ready=1 on the push cycle -> no drop, overflow stays 0, words come out in order.
//  5. Assert rst after 2 bytes with one word queued -> out_valid=0 immediately (async). After release, bytes 05..08 give 32'h08070605.
//  6. With PARITY_EN: bytes 01,03,07,00 -> out_par=4'b0101. clr_ovf asserted on the same cycle as a drop -> overflow=1.

Source files
------------

// File: rtl/byte_stream_packer.sv
// byte_stream_packer: packs upstream bytes into LANES-byte words queued in a DEPTH-entry FIFO.
// Defining BYTE_PACKER_PARITY_EN adds out_par, per-lane even parity stored with each word.
module byte_stream_packer #(
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
`ifdef BYTE_PACKER_PARITY_EN
    output logic [LANES-1:0]   out_par,
`endif
    output logic               overflow,
    input  logic               clr_ovf
);
    localparam int CW = $clog2(LANES);
    localparam int OW = $clog2(DEPTH) + 1;

    logic [CW-1:0]                 cnt;
    logic [8*LANES-1:0]            acc, word;
    logic [LANES-1:0]              keep;
    logic [DEPTH-1:0]              vld, vldNext;
    logic [DEPTH-1:0][8*LANES-1:0] memData, dataNext;
    logic [DEPTH-1:0][LANES-1:0]   memKeep, keepNext;
    logic [OW-1:0]                 occ, wrIdx;
    logic                          push, pop, drop, accept;

    // Unwritten accumulator lanes are always zero, so the word needs no masking.
    always_comb begin
        word = acc;
        keep = '0;
        for (int k = 0; k < LANES; k++) begin
            word[8*k +: 8] = (in_valid && CW'(k) == cnt) ? in_data : acc[8*k +: 8];
            keep[k] = CW'(k) < cnt || (in_valid && CW'(k) == cnt);
        end
    end

    assign push   = (in_valid && cnt == CW'(LANES - 1)) || (flush && (cnt != '0 || in_valid));
    assign pop    = vld[0] && out_ready;
    assign drop   = push && vld[DEPTH-1] && !pop;
    assign accept = push && !drop;
    assign wrIdx  = occ - OW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (push) begin
            cnt <= '0;
            acc <= '0;
        end else if (in_valid) begin
            cnt <= cnt + CW'(1);
            acc <= word;
        end
    end

    // Shift-register FIFO: entry 0 is the head and drives the outputs directly.
    always_comb begin
        vldNext  = pop ? vld >> 1 : vld;
        dataNext = pop ? memData >> (8*LANES) : memData;
        keepNext = pop ? memKeep >> LANES : memKeep;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && OW'(i) == wrIdx) begin
                vldNext[i]  = 1'b1;
                dataNext[i] = word;
                keepNext[i] = keep;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            memData  <= '0;
            memKeep  <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            vld      <= vldNext;
            memData  <= dataNext;
            memKeep  <= keepNext;
            occ      <= occ + OW'(accept) - OW'(pop);
            overflow <= drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
        end
    end

    assign out_valid = vld[0];
    assign out_data  = memData[0];
    assign out_keep  = memKeep[0];

`ifdef BYTE_PACKER_PARITY_EN
    logic [DEPTH-1:0][LANES-1:0] memPar, parNext;
    logic [LANES-1:0]            par;

    always_comb begin
        par     = '0;
        for (int k = 0; k < LANES; k++) par[k] = ^word[8*k +: 8];
        parNext = pop ? memPar >> LANES : memPar;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && OW'(i) == wrIdx) parNext[i] = par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) memPar <= '0;
        else memPar <= parNext;
    end

    assign out_par = memPar[0];
`endif
endmodule

// File: tb/tb_byte_stream_packer.sv
// tb_byte_stream_packer: directed and random checks of byte_stream_packer against a queue-based model.
module tb_byte_stream_packer;
    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst, in_valid, flush, out_valid, out_ready, overflow, clr_ovf;
    logic [7:0] in_data;
    logic [8*LANES-1:0] out_data;
    logic [LANES-1:0] out_keep;
`ifdef BYTE_PACKER_PARITY_EN
    logic [LANES-1:0] out_par;
`endif

    int tests = 0;
    int fails = 0;
    byte unsigned pend[$];
    logic [8*LANES-1:0] qData[$];
    logic [LANES-1:0] qKeep[$];
    logic [LANES-1:0] qPar[$];
    logic mOvf = 1'b0;

    always #5 clk = ~clk;

    byte_stream_packer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_keep(out_keep),
`ifdef BYTE_PACKER_PARITY_EN
        .out_par(out_par),
`endif
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        pend.delete();
        qData.delete();
        qKeep.delete();
        qPar.delete();
        mOvf = 1'b0;
    endtask

    // Bytes collect in a list; a word leaves when the list fills or a flush finds it non-empty.
    task automatic modelStep();
        bit popNow = qData.size() > 0 && out_ready;
        bit doPush = 1'b0;
        bit drop;
        logic [8*LANES-1:0] w = '0;
        logic [LANES-1:0] kp = '0;
        logic [LANES-1:0] pr = '0;
        if (in_valid) pend.push_back(in_data);
        if (pend.size() == LANES || (flush && pend.size() > 0)) begin
            doPush = 1'b1;
            foreach (pend[k]) begin
                w[8*k +: 8] = pend[k];
                kp[k] = 1'b1;
                pr[k] = ^pend[k];
            end
            pend.delete();
        end
        drop = doPush && qData.size() == DEPTH && !popNow;
        if (popNow) begin
            void'(qData.pop_front());
            void'(qKeep.pop_front());
            void'(qPar.pop_front());
        end
        if (doPush && !drop) begin
            qData.push_back(w);
            qKeep.push_back(kp);
            qPar.push_back(pr);
        end
        if (drop) mOvf = 1'b1;
        else if (clr_ovf) mOvf = 1'b0;
    endtask

    task automatic checkModel(string tag);
        logic [8*LANES-1:0] expData = '0;
        logic [LANES-1:0] expKeep = '0;
        logic [LANES-1:0] expPar = '0;
        if (qData.size() > 0) begin
            expData = qData[0];
            expKeep = qKeep[0];
            expPar = qPar[0];
        end
        check({tag, ".valid"}, 64'(out_valid), 64'(qData.size() > 0));
        check({tag, ".data"}, 64'(out_data), 64'(expData));
        check({tag, ".keep"}, 64'(out_keep), 64'(expKeep));
        check({tag, ".ovf"}, 64'(overflow), 64'(mOvf));
`ifdef BYTE_PACKER_PARITY_EN
        check({tag, ".par"}, 64'(out_par), 64'(expPar));
`else
        if (expPar === 'x) check({tag, ".parx"}, 64'(expPar), 64'd0);
`endif
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        modelStep();
        #1 checkModel(tag);
    endtask

    task automatic send(string tag, logic [7:0] b);
        in_valid = 1'b1;
        in_data = b;
        cycle(tag);
        in_valid = 1'b0;
    endtask

    task automatic idle(string tag);
        in_valid = 1'b0;
        flush = 1'b0;
        clr_ovf = 1'b0;
        cycle(tag);
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", 64'(out_data), 64'd0);
        check("rst.keep", 64'(out_keep), 64'd0);
        check("rst.ovf", 64'(overflow), 64'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        doReset();

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send("t1", 8'(i));
        check("t1.valid", 64'(out_valid), 64'd1);
        check("t1.data", 64'(out_data), 64'h04030201);
        check("t1.keep", 64'(out_keep), 64'hF);
        idle("t1.drain");

        send("t2", 8'hAA);
        send("t2", 8'hBB);
        flush = 1'b1;
        cycle("t2.flush");
        check("t2.data", 64'(out_data), 64'h0000BBAA);
        check("t2.keep", 64'(out_keep), 64'h3);
        cycle("t2.flush2");
        check("t2.noword", 64'(out_valid), 64'd0);
        flush = 1'b0;

        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send("t3", 8'(i));
        check("t3.head", 64'(out_data), 64'h03020100);
        check("t3.ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        idle("t3.pop1");
        check("t3.second", 64'(out_data), 64'h07060504);
        idle("t3.pop2");
        check("t3.empty", 64'(out_valid), 64'd0);
        clr_ovf = 1'b1;
        cycle("t3.clr");
        clr_ovf = 1'b0;
        check("t3.clr", 64'(overflow), 64'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send("t4", 8'(8'h10 + i));
        out_ready = 1'b1;
        send("t4.pushpop", 8'h1B);
        check("t4.ovf", 64'(overflow), 64'd0);
        check("t4.head", 64'(out_data), 64'h17161514);
        idle("t4.d1");
        check("t4.last", 64'(out_data), 64'h1B1A1918);
        idle("t4.d2");

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send("t5", 8'(8'h20 + i));
        #2 rst = 1'b1;
        modelClear();
        #1;
        check("t5.async.valid", 64'(out_valid), 64'd0);
        check("t5.async.data", 64'(out_data), 64'd0);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send("t5", 8'(i));
        check("t5.word", 64'(out_data), 64'h08070605);
        idle("t5.drain");

        send("t6", 8'h01);
        send("t6", 8'h03);
        send("t6", 8'h07);
        send("t6", 8'h00);
`ifdef BYTE_PACKER_PARITY_EN
        check("t6.par", 64'(out_par), 64'b0101);
`endif
        idle("t6.drain");
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send("t6.fill", 8'(8'h40 + i));
        clr_ovf = 1'b1;
        send("t6.dropclr", 8'h4B);
        check("t6.ovfwins", 64'(overflow), 64'd1);
        cycle("t6.clr");
        clr_ovf = 1'b0;
        check("t6.clr", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        idle("t6.d1");
        idle("t6.d2");

        for (int n = 0; n < 4000; n++) begin
            in_valid = $urandom_range(0, 99) < 70;
            in_data = 8'($urandom);
            flush = $urandom_range(0, 99) < 10;
            out_ready = $urandom_range(0, 99) < 50;
            clr_ovf = $urandom_range(0, 99) < 5;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
